// File: rtl/seg_scan_decoder.sv
// Seven-segment scan-bus observer: rebuilds the displayed digits as packed BCD.
// Optional stall watchdog is built only when SCAN_WATCHDOG_EN is defined.
module seg_scan_decoder #(
   parameter int unsigned NUM_DIG        = 8,
   parameter int unsigned SETTLE         = 4,
   parameter int unsigned DIG_ACTIVE_LOW = 1,
   parameter int unsigned SEG_ACTIVE_LOW = 0,
   parameter int unsigned WDOG_CYCLES    = 1000000
) (
   input  logic                   clk_50M,
   input  logic                   clear,
   input  logic [NUM_DIG-1:0]     DIG,
   input  logic [6:0]             codeout,
   output logic [4*NUM_DIG-1:0]   frame_bcd,
   output logic [NUM_DIG-1:0]     blank_mask,
   output logic                   frame_valid,
   output logic                   frame_changed,
   output logic                   seg_err,
   output logic                   dig_err,
   output logic                   scan_stall
);

   localparam logic [7:0] CNT_SAT = 8'(SETTLE);
   localparam logic [7:0] CAP_AT  = (SETTLE > 1) ? 8'(SETTLE - 2) : 8'd0;

   typedef enum logic {COLLECT, EMIT} state_t;

   logic [NUM_DIG-1:0]   dig_norm, sel_meta, sel, sel_prev;
   logic [6:0]           seg_norm, seg_meta, seg, seg_prev;
   logic [7:0]           cnt;
   logic                 same, stable_evt, multi, onehot, capture, dig_bad;
   logic [3:0]           nib;
   logic                 is_blank, is_bad;
   state_t               state;
   logic [NUM_DIG-1:0]   seen, seen_base, seen_next;
   logic [4*NUM_DIG-1:0] work, work_next;
   logic [NUM_DIG-1:0]   blank_work, blank_next;
   logic                 done;

   assign dig_norm = (DIG_ACTIVE_LOW != 0) ? ~DIG : DIG;
   assign seg_norm = (SEG_ACTIVE_LOW != 0) ? ~codeout : codeout;

   always_ff @(posedge clk_50M) begin
      if (clear) begin
         sel_meta <= '0;
         seg_meta <= '0;
         sel      <= '0;
         seg      <= '0;
         sel_prev <= '0;
         seg_prev <= '0;
         cnt      <= '0;
      end else begin
         sel_meta <= dig_norm;
         seg_meta <= seg_norm;
         sel      <= sel_meta;
         seg      <= seg_meta;
         sel_prev <= sel;
         seg_prev <= seg;
         if (!same)
            cnt <= '0;
         else if (cnt != CNT_SAT)
            cnt <= cnt + 8'd1;
      end
   end

   // Fires on the cycle cnt steps to SETTLE-1, i.e. the SETTLE-th identical sample.
   assign same       = ({sel, seg} == {sel_prev, seg_prev});
   assign stable_evt = (SETTLE > 1) ? (same && (cnt == CAP_AT)) : !same;
   assign multi      = (sel & (sel - NUM_DIG'(1))) != '0;
   assign onehot     = (sel != '0) && !multi;
   assign capture    = stable_evt && onehot;
   assign dig_bad    = stable_evt && multi;

   always_comb begin
      nib      = 4'hE;
      is_blank = 1'b0;
      is_bad   = 1'b0;
      case (seg)
         7'h3F:        nib = 4'd0;
         7'h06:        nib = 4'd1;
         7'h5B:        nib = 4'd2;
         7'h4F:        nib = 4'd3;
         7'h66:        nib = 4'd4;
         7'h6D:        nib = 4'd5;
         7'h7D, 7'h7C: nib = 4'd6;
         7'h07, 7'h27: nib = 4'd7;
         7'h7F:        nib = 4'd8;
         7'h6F, 7'h67: nib = 4'd9;
         7'h00: begin
            nib      = 4'hF;
            is_blank = 1'b1;
         end
         default:      is_bad = 1'b1;
      endcase
   end

   // EMIT clears seen, but a capture landing in EMIT already counts for the next frame.
   always_comb begin
      seen_base  = (state == EMIT) ? '0 : seen;
      seen_next  = seen_base;
      work_next  = work;
      blank_next = blank_work;
      if (capture) begin
         for (int unsigned i = 0; i < NUM_DIG; i++) begin
            if (sel[i]) begin
               work_next[4*i +: 4] = nib;
               blank_next[i]       = is_blank;
               seen_next[i]        = 1'b1;
            end
         end
      end
      done = capture && (&seen_next);
   end

   // Outputs are loaded on the completing edge so frame_valid appears in the EMIT cycle;
   // the output registers double as the previous-frame shadow.
   always_ff @(posedge clk_50M) begin
      if (clear) begin
         state         <= COLLECT;
         seen          <= '0;
         work          <= '0;
         blank_work    <= '0;
         frame_bcd     <= '0;
         blank_mask    <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         seg_err       <= 1'b0;
         dig_err       <= 1'b0;
      end else begin
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         seen          <= seen_next;
         work          <= work_next;
         blank_work    <= blank_next;
         if (capture && is_bad)
            seg_err <= 1'b1;
         if (dig_bad)
            dig_err <= 1'b1;
         if (done) begin
            state         <= EMIT;
            frame_bcd     <= work_next;
            blank_mask    <= blank_next;
            frame_valid   <= 1'b1;
            frame_changed <= ({work_next, blank_next} != {frame_bcd, blank_mask});
         end else begin
            state <= COLLECT;
         end
      end
   end

`ifdef SCAN_WATCHDOG_EN
   localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;

   always_ff @(posedge clk_50M) begin
      if (clear) begin
         wdog_cnt   <= '0;
         scan_stall <= 1'b0;
      end else if (capture) begin
         wdog_cnt   <= '0;
         scan_stall <= 1'b0;
      end else if (wdog_cnt != WW'(WDOG_CYCLES)) begin
         wdog_cnt <= wdog_cnt + WW'(1);
         if (wdog_cnt == WW'(WDOG_CYCLES - 1))
            scan_stall <= 1'b1;
      end
   end
`else
   assign scan_stall = 1'b0;
`endif

endmodule
